gorkans_input: RTL and testbench
================================

GORKANS_INPUT -- requirements
Module: gorkans_input

Interface
REQ-001 Parameter COIN_FRAMES, default 4, number of frame ticks the coin bit stays asserted per credit; legal range 1..255.
REQ-002 Parameter COIN_GAP, default 8, number of frame ticks of forced coin-low gap after each pulse; legal range 1..255.
REQ-003 clk_sys  in  1  single system clock; all logic on its rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 ps2_key  in  65  keyboard event bus:
- bit 64 toggles once per event.
- [63:24] prefix bytes.
- [23:16] second byte.
- [15:8] break/extend byte.
- [7:0] scan code.
REQ-006 joystick_0  in  16  player-1 pad: bit0 right, bit1 left, bit2 down, bit3 up, bit4 fire, bit5 start1, bit6 start2.
REQ-007 joystick_1  in  16  player-2 pad, same layout as joystick_0.
REQ-008 rotate  in  1  1 = horizontal cabinet orientation; controls are remapped.
REQ-009 vblank  in  1  video vertical blank, synchronous to clk_sys.
REQ-010 in0  out  8  active-low core port: {2'b00, coin, 0, down, right, left, up}, inverted.
REQ-011 in1  out  8  active-low core port: {0, start2, start1, fire, 4'b0000}, inverted.

Function
REQ-012 Keyboard event detection:
- Register ps2_key[64] each cycle.
- An event is a cycle where ps2_key[64] differs from its registered value.
- Events with ps2_key[63:24] nonzero are ignored (PrtScr/Pause filter).
REQ-013 Event decoding:
- pressed = (ps2_key[15:8] != 8'hF0).
- extended = pressed ? (ps2_key[15:8] == 8'hE0) : (ps2_key[23:16] == 8'hE0).
- Key identity is the 9-bit value {extended, ps2_key[7:0]}.
REQ-014 Key map; each key has its own state flop, loaded with pressed on a matching event:
- X75 up, X72 down, X6B left, X74 right (the extended bit is ignored for these).
- 029 space, 014 ctrl.
- 005 F1 = start1, 006 F2 = start2.
REQ-015 Combined buttons:
- joy = joystick_0 | joystick_1.
- fire = space | ctrl | joy[4].
- start1 = F1 | joy[5].
- start2 = F2 | joy[6].
REQ-016 rotate=0 direction mapping (keyboard | joy):
- up = up | joy[3]; down = down | joy[2].
- left = left | joy[1]; right = right | joy[0].
REQ-017 rotate=1 direction mapping (keyboard | joy):
- up = left | joy[1]; down = right | joy[0].
- left = down | joy[2]; right = up | joy[3].
REQ-018 Frame tick = rising edge of vblank (registered vblank was 0, current vblank is 1).
REQ-019 Coin request = rising edge of (start1 | start2); holding a start button produces exactly one request.
REQ-020 Coin FSM states IDLE, PULSE, GAP, with an 8-bit down-counter cnt.
REQ-021 IDLE:
- On a request (or pending=1), go to PULSE, load cnt = COIN_FRAMES, clear pending.
- A frame tick in the same cycle is not counted.
REQ-022 PULSE:
- coin = 1.
- Each frame tick decrements cnt.
- On a tick with cnt == 1, go to GAP and load cnt = COIN_GAP.
REQ-023 GAP:
- coin = 0.
- Each frame tick decrements cnt.
- On a tick with cnt == 1, go to PULSE (reload COIN_FRAMES) if pending, else IDLE.
REQ-024 A request in PULSE or GAP sets the single-entry flag pending; further requests while pending=1 are dropped.
REQ-025 A request in the same cycle as the GAP-exit tick counts as pending, so the next state is PULSE.
REQ-026 in0 and in1 are registered:
- A key event changes the output one cycle after the event cycle.
- Joystick changes appear one cycle after they occur.
REQ-027 coin appears in in0 bit 5 one cycle after the FSM enters PULSE.

Reset
REQ-028 While reset_n = 0:
- All key flops = 0.
- Toggle and vblank history flops = 0.
- FSM in IDLE, cnt = 0, pending = 0.
- in0 = 8'hFF, in1 = 8'hFF.
REQ-029 Release of reset_n needs no synchronizer inside the block; the integrating top provides one.
REQ-030 Reset asserted mid-pulse aborts the pulse immediately; coin reads 1 (inactive) at the output with no further edges.
REQ-031 If the toggle bit differs from 0 at reset release, no event is decoded in the first cycle.

Structure
REQ-032 Shared package gorkans_input_pkg holds:
- Scan-code constants.
- The coin state enum (IDLE/PULSE/GAP).
- in0/in1 bit-position constants.
REQ-033 Coin FSM plus counter lives in one sub-module, coin_pulse_fsm, with ports clk_sys, reset_n, req, tick, coin.

Verification
REQ-034 Event F1 make (ps2_key[15:0]=16'h0005, toggle) -> in1 = 8'hDF next cycle, and in0 bit 5 = 0 one cycle after PULSE entry.
REQ-035 Hold start1 with 10 frame ticks, defaults -> in0 bit 5 low for exactly 4 ticks, then high; only one pulse.
REQ-036 Two start presses 2 ticks apart, then a third press -> two pulses separated by an 8-tick gap; third press dropped only if it arrives while pending=1.
REQ-037 rotate=1, joystick_0=16'h0008 (up) -> in0 = 8'hFB (right active).
REQ-038 Ctrl make, space make, ctrl break (E0-less F0 14) -> fire stays active until space break; in1 bit 4 = 0 throughout.
REQ-039 reset_n pulsed low during PULSE, and an event with ps2_key[63:24] = 1 -> outputs return to 8'hFF asynchronously; the filtered event changes nothing.

Source files
------------

// File: rtl/gorkans_input_pkg.sv
// Shared constants and types for the gorkans_input keyboard/joystick front end.
package gorkans_input_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StPulse,
    StGap
  } coin_state_e;

  typedef struct packed {
    logic up;
    logic down;
    logic left;
    logic right;
    logic space;
    logic ctrl;
    logic f1;
    logic f2;
  } key_state_t;

  // PS/2 prefix bytes
  localparam logic [7:0] ScBreak  = 8'hF0;
  localparam logic [7:0] ScExtend = 8'hE0;

  // Arrow scan codes; the extended flag is not compared for these
  localparam logic [7:0] ScUp    = 8'h75;
  localparam logic [7:0] ScDown  = 8'h72;
  localparam logic [7:0] ScLeft  = 8'h6B;
  localparam logic [7:0] ScRight = 8'h74;

  // Full 9-bit key identities {extended, scan code}
  localparam logic [8:0] KeySpace = 9'h029;
  localparam logic [8:0] KeyCtrl  = 9'h014;
  localparam logic [8:0] KeyF1    = 9'h005;
  localparam logic [8:0] KeyF2    = 9'h006;

  // Joystick bit positions
  localparam int unsigned JoyRight  = 0;
  localparam int unsigned JoyLeft   = 1;
  localparam int unsigned JoyDown   = 2;
  localparam int unsigned JoyUp     = 3;
  localparam int unsigned JoyFire   = 4;
  localparam int unsigned JoyStart1 = 5;
  localparam int unsigned JoyStart2 = 6;

  // Core port bit positions (active low)
  localparam int unsigned In0Up     = 0;
  localparam int unsigned In0Left   = 1;
  localparam int unsigned In0Right  = 2;
  localparam int unsigned In0Down   = 3;
  localparam int unsigned In0Coin   = 5;
  localparam int unsigned In1Fire   = 4;
  localparam int unsigned In1Start1 = 5;
  localparam int unsigned In1Start2 = 6;

endpackage

// File: rtl/gorkans_input_coin_pulse_fsm.sv
// Turns start-button requests into timed coin pulses counted in frame ticks,
// with one queued credit allowed while a pulse or its gap is in progress.
module coin_pulse_fsm
  import gorkans_input_pkg::*;
#(
  parameter int unsigned COIN_FRAMES = 4,
  parameter int unsigned COIN_GAP    = 8
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic req,
  input  logic tick,
  output logic coin
);

  localparam logic [7:0] FramesLoad = 8'(COIN_FRAMES);
  localparam logic [7:0] GapLoad    = 8'(COIN_GAP);

  coin_state_e state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        pending_q, pending_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pending_d = pending_q;
    coin      = 1'b0;
    case (state_q)
      StIdle: begin
        // Ticks arriving on the start cycle are deliberately not counted
        if (req || pending_q) begin
          state_d   = StPulse;
          cnt_d     = FramesLoad;
          pending_d = 1'b0;
        end
      end
      StPulse: begin
        coin = 1'b1;
        if (req) pending_d = 1'b1;
        if (tick) begin
          if (cnt_q == 8'd1) begin
            state_d = StGap;
            cnt_d   = GapLoad;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
      end
      StGap: begin
        if (tick && (cnt_q == 8'd1)) begin
          // A request landing on the exit tick still earns the next pulse
          if (pending_q || req) begin
            state_d   = StPulse;
            cnt_d     = FramesLoad;
            pending_d = 1'b0;
          end else begin
            state_d = StIdle;
            cnt_d   = 8'd0;
          end
        end else begin
          if (tick) cnt_d = cnt_q - 8'd1;
          if (req) pending_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      cnt_q     <= 8'd0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
    end
  end

endmodule

// File: rtl/gorkans_input.sv
// Keyboard/joystick front end: decodes PS/2 events into key state, merges pads,
// applies cabinet rotation and drives the active-low core ports with a coin pulse.
module gorkans_input
  import gorkans_input_pkg::*;
#(
  parameter int unsigned COIN_FRAMES = 4,
  parameter int unsigned COIN_GAP    = 8
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [64:0] ps2_key,
  input  logic [15:0] joystick_0,
  input  logic [15:0] joystick_1,
  input  logic        rotate,
  input  logic        vblank,
  output logic [7:0]  in0,
  output logic [7:0]  in1
);

  logic       tog_q, tog_d;
  logic       armed_q, armed_d;
  logic       vblank_q, vblank_d;
  logic       start_q, start_d;
  key_state_t keys_q, keys_d;
  logic [7:0] in0_q, in0_d;
  logic [7:0] in1_q, in1_d;

  logic       key_event, pressed, extended;
  logic [8:0] key_id;
  logic [6:0] joy;
  logic       fire, start1, start2;
  logic       dir_up, dir_down, dir_left, dir_right;
  logic       req, tick, coin;
  logic       unused_joy;

  assign unused_joy = ^{joystick_0[15:7], joystick_1[15:7]};

  // armed_q masks the first cycle after reset, when tog_q is not yet valid
  always_comb begin
    key_event = armed_q && (ps2_key[64] != tog_q) && (ps2_key[63:24] == 40'd0);
    pressed   = (ps2_key[15:8] != ScBreak);
    extended  = pressed ? (ps2_key[15:8] == ScExtend) : (ps2_key[23:16] == ScExtend);
    key_id    = {extended, ps2_key[7:0]};
    keys_d    = keys_q;
    if (key_event) begin
      case (ps2_key[7:0])
        ScUp:    keys_d.up    = pressed;
        ScDown:  keys_d.down  = pressed;
        ScLeft:  keys_d.left  = pressed;
        ScRight: keys_d.right = pressed;
        default: ;
      endcase
      case (key_id)
        KeySpace: keys_d.space = pressed;
        KeyCtrl:  keys_d.ctrl  = pressed;
        KeyF1:    keys_d.f1    = pressed;
        KeyF2:    keys_d.f2    = pressed;
        default:  ;
      endcase
    end
  end

  // Outputs are built from next-state key values so they land one cycle after the event
  always_comb begin
    joy    = joystick_0[6:0] | joystick_1[6:0];
    fire   = keys_d.space | keys_d.ctrl | joy[JoyFire];
    start1 = keys_d.f1 | joy[JoyStart1];
    start2 = keys_d.f2 | joy[JoyStart2];
    if (rotate) begin
      dir_up    = keys_d.left  | joy[JoyLeft];
      dir_down  = keys_d.right | joy[JoyRight];
      dir_left  = keys_d.down  | joy[JoyDown];
      dir_right = keys_d.up    | joy[JoyUp];
    end else begin
      dir_up    = keys_d.up    | joy[JoyUp];
      dir_down  = keys_d.down  | joy[JoyDown];
      dir_left  = keys_d.left  | joy[JoyLeft];
      dir_right = keys_d.right | joy[JoyRight];
    end

    start_d  = start1 | start2;
    req      = start_d & ~start_q;
    vblank_d = vblank;
    tick     = vblank & ~vblank_q;
    tog_d    = ps2_key[64];
    armed_d  = 1'b1;

    in0_d          = 8'hFF;
    in0_d[In0Up]    = ~dir_up;
    in0_d[In0Left]  = ~dir_left;
    in0_d[In0Right] = ~dir_right;
    in0_d[In0Down]  = ~dir_down;
    in0_d[In0Coin]  = ~coin;

    in1_d            = 8'hFF;
    in1_d[In1Fire]   = ~fire;
    in1_d[In1Start1] = ~start1;
    in1_d[In1Start2] = ~start2;
  end

  coin_pulse_fsm #(
    .COIN_FRAMES(COIN_FRAMES),
    .COIN_GAP   (COIN_GAP)
  ) u_coin (
    .clk_sys(clk_sys),
    .reset_n(reset_n),
    .req    (req),
    .tick   (tick),
    .coin   (coin)
  );

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      tog_q    <= 1'b0;
      armed_q  <= 1'b0;
      vblank_q <= 1'b0;
      start_q  <= 1'b0;
      keys_q   <= '0;
      in0_q    <= 8'hFF;
      in1_q    <= 8'hFF;
    end else begin
      tog_q    <= tog_d;
      armed_q  <= armed_d;
      vblank_q <= vblank_d;
      start_q  <= start_d;
      keys_q   <= keys_d;
      in0_q    <= in0_d;
      in1_q    <= in1_d;
    end
  end

  assign in0 = in0_q;
  assign in1 = in1_q;

endmodule

// File: tb/tb_gorkans_input.sv
// Self-checking bench for gorkans_input: constant vector table, hand-written coin
// sequences and randomized traffic against a frame-counting reference model.
module tb_gorkans_input;

  localparam int CF = 4;
  localparam int CG = 8;

  logic        clk_sys;
  logic        reset_n;
  logic [64:0] ps2_key;
  logic [15:0] joystick_0;
  logic [15:0] joystick_1;
  logic        rotate;
  logic        vblank;
  logic [7:0]  in0;
  logic [7:0]  in1;

  gorkans_input #(
    .COIN_FRAMES(CF),
    .COIN_GAP   (CG)
  ) dut (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .ps2_key   (ps2_key),
    .joystick_0(joystick_0),
    .joystick_1(joystick_1),
    .rotate    (rotate),
    .vblank    (vblank),
    .in0       (in0),
    .in1       (in1)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit k_up, k_down, k_left, k_right, k_space, k_ctrl, k_f1, k_f2;
  bit m_tog, m_armed, m_vb, m_sprev;
  bit m_busy, m_pend;
  int m_ticks;  // frame ticks since the current pulse began
  logic [7:0] m_in0, m_in1;

  // Bench observation of coin activity
  bit cur_tog;
  bit obs_vb, prev_coin;
  int falls, lo_ticks, gap_ticks;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h, expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    {k_up, k_down, k_left, k_right, k_space, k_ctrl, k_f1, k_f2} = '0;
    m_tog = 0; m_armed = 0; m_vb = 0; m_sprev = 0;
    m_busy = 0; m_pend = 0; m_ticks = 0;
    m_in0 = 8'hFF; m_in1 = 8'hFF;
    obs_vb = 0; prev_coin = 1;
  endtask

  task automatic model_step();
    bit ev, pr, ext, u, d, l, r, fire, s1, s2, req, tick, coin_now, exiting;
    logic [8:0] id;
    logic [15:0] joy;
    ev  = m_armed && (ps2_key[64] != m_tog) && (ps2_key[63:24] == 40'd0);
    pr  = (ps2_key[15:8] != 8'hF0);
    ext = pr ? (ps2_key[15:8] == 8'hE0) : (ps2_key[23:16] == 8'hE0);
    id  = {ext, ps2_key[7:0]};
    if (ev) begin
      if (ps2_key[7:0] == 8'h75) k_up = pr;
      if (ps2_key[7:0] == 8'h72) k_down = pr;
      if (ps2_key[7:0] == 8'h6B) k_left = pr;
      if (ps2_key[7:0] == 8'h74) k_right = pr;
      if (id == 9'h029) k_space = pr;
      if (id == 9'h014) k_ctrl = pr;
      if (id == 9'h005) k_f1 = pr;
      if (id == 9'h006) k_f2 = pr;
    end
    joy  = joystick_0 | joystick_1;
    fire = k_space | k_ctrl | joy[4];
    s1   = k_f1 | joy[5];
    s2   = k_f2 | joy[6];
    if (!rotate) begin
      u = k_up | joy[3];   d = k_down | joy[2];
      l = k_left | joy[1]; r = k_right | joy[0];
    end else begin
      u = k_left | joy[1]; d = k_right | joy[0];
      l = k_down | joy[2]; r = k_up | joy[3];
    end
    req  = (s1 | s2) && !m_sprev;
    tick = vblank && !m_vb;
    coin_now = m_busy && (m_ticks < CF);
    m_in0 = ~{2'b00, coin_now, 1'b0, d, r, l, u};
    m_in1 = ~{1'b0, s2, s1, fire, 4'b0000};
    if (!m_busy) begin
      if (req || m_pend) begin
        m_busy = 1; m_ticks = 0; m_pend = 0;
      end
    end else begin
      exiting = tick && (m_ticks == CF + CG - 1);
      if (tick) m_ticks++;
      if (exiting) begin
        if (m_pend || req) begin
          m_ticks = 0; m_pend = 0;
        end else begin
          m_busy = 0;
        end
      end else if (req) begin
        m_pend = 1;
      end
    end
    m_tog = ps2_key[64]; m_vb = vblank; m_sprev = s1 | s2; m_armed = 1;
  endtask

  task automatic cycle();
    if (vblank && !obs_vb) begin
      if (!in0[5]) lo_ticks++;
      else if (falls == 1) gap_ticks++;
    end
    obs_vb = vblank;
    model_step();
    @(posedge clk_sys);
    #1;
    check8("model_in0", in0, m_in0);
    check8("model_in1", in1, m_in1);
    if (prev_coin && !in0[5]) falls++;
    prev_coin = in0[5];
  endtask

  task automatic set_ps2(input bit flip, input logic [39:0] pre, input logic [7:0] b2,
                         input logic [7:0] brk, input logic [7:0] code);
    if (flip) cur_tog = ~cur_tog;
    ps2_key = {cur_tog, pre, b2, brk, code};
  endtask

  task automatic frame();
    vblank = 0;
    repeat (3) cycle();
    vblank = 1;
    repeat (2) cycle();
    vblank = 0;
  endtask

  task automatic frame_req();
    vblank = 0;
    repeat (3) cycle();
    vblank = 1;
    joystick_0[5] = 1;
    cycle();
    joystick_0[5] = 0;
    cycle();
    vblank = 0;
  endtask

  task automatic press2();
    joystick_0[6] = 1;
    cycle();
    joystick_0[6] = 0;
    cycle();
  endtask

  task automatic clear_obs();
    falls = 0; lo_ticks = 0; gap_ticks = 0;
  endtask

  typedef struct {
    bit          tgl;
    logic [39:0] pre;
    logic [7:0]  b2;
    logic [7:0]  brk;
    logic [7:0]  code;
    logic [15:0] j0;
    logic [15:0] j1;
    bit          rot;
    logic [7:0]  e0;
    logic [7:0]  e1;
  } vec_t;

  vec_t tbl[21];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{0, 40'h0, 8'h00, 8'h00, 8'h00, 16'h0000, 16'h0000, 0, 8'hFF, 8'hFF};
    tbl[1]  = '{1, 40'h0, 8'h00, 8'h00, 8'h75, 16'h0000, 16'h0000, 0, 8'hFE, 8'hFF};
    tbl[2]  = '{1, 40'h0, 8'h00, 8'hF0, 8'h75, 16'h0000, 16'h0000, 0, 8'hFF, 8'hFF};
    tbl[3]  = '{1, 40'h0, 8'h00, 8'hE0, 8'h74, 16'h0000, 16'h0000, 0, 8'hFB, 8'hFF};
    tbl[4]  = '{0, 40'h0, 8'h00, 8'h00, 8'h00, 16'h0000, 16'h0000, 1, 8'hF7, 8'hFF};
    tbl[5]  = '{1, 40'h0, 8'h00, 8'h00, 8'h29, 16'h0000, 16'h0000, 1, 8'hF7, 8'hEF};
    tbl[6]  = '{1, 40'h1, 8'h00, 8'hF0, 8'h29, 16'h0000, 16'h0000, 1, 8'hF7, 8'hEF};
    tbl[7]  = '{1, 40'h0, 8'h00, 8'hF0, 8'h29, 16'h0000, 16'h0000, 1, 8'hF7, 8'hFF};
    tbl[8]  = '{1, 40'h0, 8'hE0, 8'hF0, 8'h74, 16'h0000, 16'h0000, 1, 8'hFF, 8'hFF};
    tbl[9]  = '{0, 40'h0, 8'h00, 8'h00, 8'h00, 16'h0000, 16'h0010, 0, 8'hFF, 8'hEF};
    tbl[10] = '{0, 40'h0, 8'h00, 8'h00, 8'h00, 16'h0003, 16'h0010, 0, 8'hF9, 8'hEF};
    tbl[11] = '{0, 40'h0, 8'h00, 8'h00, 8'h00, 16'h0008, 16'h0000, 1, 8'hFB, 8'hFF};
    tbl[12] = '{0, 40'h0, 8'h00, 8'h00, 8'h00, 16'h0004, 16'h0000, 1, 8'hFD, 8'hFF};
    tbl[13] = '{1, 40'h0, 8'h00, 8'hE0, 8'h14, 16'h0000, 16'h0000, 0, 8'hFF, 8'hFF};
    tbl[14] = '{1, 40'h0, 8'h00, 8'hE0, 8'h6B, 16'h0000, 16'h0000, 0, 8'hFD, 8'hFF};
    tbl[15] = '{1, 40'h0, 8'h00, 8'hF0, 8'h6B, 16'h0000, 16'h0000, 0, 8'hFF, 8'hFF};
    tbl[16] = '{1, 40'h0, 8'h00, 8'h00, 8'h14, 16'h0000, 16'h0000, 0, 8'hFF, 8'hEF};
    tbl[17] = '{1, 40'h0, 8'h00, 8'h00, 8'h29, 16'h0000, 16'h0000, 0, 8'hFF, 8'hEF};
    tbl[18] = '{1, 40'h0, 8'h00, 8'hF0, 8'h14, 16'h0000, 16'h0000, 0, 8'hFF, 8'hEF};
    tbl[19] = '{1, 40'h0, 8'h00, 8'hF0, 8'h29, 16'h0000, 16'h0000, 0, 8'hFF, 8'hFF};
    tbl[20] = '{0, 40'h0, 8'h00, 8'h00, 8'h00, 16'hFF80, 16'hFF80, 0, 8'hFF, 8'hFF};

    reset_n = 0; ps2_key = '0; joystick_0 = '0; joystick_1 = '0; rotate = 0; vblank = 0;
    cur_tog = 0;
    model_reset();
    clear_obs();
    repeat (3) @(posedge clk_sys);
    #1;
    check8("reset_in0", in0, 8'hFF);
    check8("reset_in1", in1, 8'hFF);

    // Toggle already high with an up-arrow code when reset lifts: no event
    set_ps2(1, 40'h0, 8'h00, 8'h00, 8'h75);
    reset_n = 1;
    cycle();
    check8("release_no_event_1", in0, 8'hFF);
    cycle();
    check8("release_no_event_2", in0, 8'hFF);

    for (int i = 0; i < 21; i++) begin
      set_ps2(tbl[i].tgl, tbl[i].pre, tbl[i].b2, tbl[i].brk, tbl[i].code);
      joystick_0 = tbl[i].j0;
      joystick_1 = tbl[i].j1;
      rotate     = tbl[i].rot;
      cycle();
      check8($sformatf("tbl%0d_in0", i), in0, tbl[i].e0);
      check8($sformatf("tbl%0d_in1", i), in1, tbl[i].e1);
    end
    joystick_0 = '0; joystick_1 = '0; rotate = 0;

    // F1 make: start1 next cycle, coin one cycle after the FSM enters PULSE
    set_ps2(1, 40'h0, 8'h00, 8'h00, 8'h05);
    cycle();
    check8("f1_in1", in1, 8'hDF);
    check8("f1_coin_not_yet", {7'd0, in0[5]}, 8'd1);
    cycle();
    check8("f1_coin_active", {7'd0, in0[5]}, 8'd0);
    set_ps2(1, 40'h0, 8'h00, 8'hF0, 8'h05);
    cycle();
    check8("f1_break_in1", in1, 8'hFF);
    repeat (14) frame();
    check8("f1_coin_done", {7'd0, in0[5]}, 8'd1);

    // Holding start1 for 10 frames yields a single 4-tick pulse
    clear_obs();
    joystick_0 = 16'h0020;
    repeat (2) cycle();
    repeat (10) frame();
    check8("hold_pulses", 8'(falls), 8'd1);
    check8("hold_low_ticks", 8'(lo_ticks), 8'd4);
    joystick_0 = '0;
    repeat (6) frame();

    // Two presses two ticks apart plus a third while pending: two pulses, 8-tick gap
    clear_obs();
    press2();
    frame(); frame();
    press2();
    press2();
    repeat (30) frame();
    check8("queue_pulses", 8'(falls), 8'd2);
    check8("queue_low_ticks", 8'(lo_ticks), 8'd8);
    check8("queue_gap_ticks", 8'(gap_ticks), 8'd8);

    // Request on the gap-exit tick starts a second pulse
    clear_obs();
    press2();
    repeat (11) frame();
    frame_req();
    repeat (16) frame();
    check8("gap_exit_req_pulses", 8'(falls), 8'd2);

    // Reset mid-pulse returns outputs to idle asynchronously
    set_ps2(1, 40'h0, 8'h00, 8'h00, 8'h29);
    cycle();
    press2();
    frame();
    check8("pre_reset_coin", {7'd0, in0[5]}, 8'd0);
    check8("pre_reset_in1", in1, 8'hEF);
    #2 reset_n = 0;
    #1;
    check8("async_reset_in0", in0, 8'hFF);
    check8("async_reset_in1", in1, 8'hFF);
    model_reset();
    @(posedge clk_sys);
    #1;
    check8("held_reset_in0", in0, 8'hFF);
    reset_n = 1;
    repeat (2) cycle();
    set_ps2(1, 40'h1, 8'h00, 8'h00, 8'h05);
    cycle();
    check8("filtered_in1", in1, 8'hFF);
    repeat (3) cycle();
    check8("filtered_in0", in0, 8'hFF);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        logic [7:0] codes [8];
        logic [39:0] pre;
        logic [7:0] b2, brk, code;
        codes = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h29, 8'h14, 8'h05, 8'h06};
        pre  = ($urandom_range(0, 7) == 0) ? 40'($urandom_range(1, 255)) << 8 * $urandom_range(0, 4)
                                           : 40'h0;
        b2   = ($urandom_range(0, 1) == 0) ? 8'hE0 : 8'($urandom);
        case ($urandom_range(0, 3))
          0: brk = 8'h00;
          1: brk = 8'hF0;
          2: brk = 8'hE0;
          default: brk = 8'($urandom);
        endcase
        code = ($urandom_range(0, 5) == 0) ? 8'($urandom) : codes[$urandom_range(0, 7)];
        set_ps2(1, pre, b2, brk, code);
      end
      if ($urandom_range(0, 9) == 0) joystick_0 = 16'($urandom) & 16'($urandom);
      if ($urandom_range(0, 9) == 0) joystick_1 = 16'($urandom) & 16'($urandom);
      if ($urandom_range(0, 49) == 0) rotate = ~rotate;
      vblank = ($urandom_range(0, 3) == 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
